// File: rtl/dlx_sequencer.sv
// dlx_sequencer: multicycle control automaton for the DLX core.
// Produces one-cycle phase strobes IF/ID/EX/MEM/WB. Waits on the instruction
// and data handshakes, skips MEM/WB when the decoded instruction needs neither,
// and keeps halt, bus-timeout and retired/stall counters.
//
// Parameters
//   TIMEOUT   consecutive wait cycles in FETCH/MEMACC before ERR (0 = never)
//   CNT_W     width of retired / stall_cycles
//   SKIP_MEM  1: bypass MEM when mem_op=0 and WB when wb_en=0; 0: all phases
// Ports
//   clk, reset_n            clock (rising) / async active-low reset
//   enable, halt_req        run request / stop at next instruction boundary
//   i_data_valid            instruction ROM data valid
//   d_data_valid            data RAM access complete
//   mem_op, wb_en           decoder flags, sampled in DECODE
//   IF, ID, EX, MEM, WB     phase strobes (at most one high per cycle)
//   i_req, d_req            fetch / data access requests
//   busy, error             running / sticky bus-timeout
//   retired, stall_cycles   saturating counters
module dlx_sequencer #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SKIP_MEM = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             halt_req,
    input  logic             i_data_valid,
    input  logic             d_data_valid,
    input  logic             mem_op,
    input  logic             wb_en,
    output logic             IF,
    output logic             ID,
    output logic             EX,
    output logic             MEM,
    output logic             WB,
    output logic             i_req,
    output logic             d_req,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stall_cycles
);

    // Wait counter only has to hold 0..TIMEOUT-1: the TIMEOUT-th wait goes to ERR.
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          SKIP   = (SKIP_MEM != 0);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEMACC, WRBACK, ERR
    } state_t;

    state_t            state;
    state_t            after_bnd;
    logic              mem_q;
    logic              wb_q;
    logic              halt_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              mem_done;
    logic              boundary;
    logic              timeout_hit;

    always_comb begin
        waiting  = 1'b0;
        mem_done = 1'b0;
        boundary = 1'b0;
        case (state)
            FETCH:  waiting = !i_data_valid;
            EXEC:   boundary = !(mem_q || !SKIP) && !wb_q;
            MEMACC: begin
                // Non-memory visits (SKIP_MEM=0) complete without a handshake.
                waiting  = mem_q && !d_data_valid;
                mem_done = !(mem_q && !d_data_valid);
                boundary = mem_done && !(wb_q || !SKIP);
            end
            WRBACK: boundary = 1'b1;
            default: ;
        endcase
        timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_W'(TO_LIM));
        after_bnd   = (halt_q || !enable) ? IDLE : FETCH;
    end

    // Strobes decode the current state; IF and MEM follow the valids combinationally.
    always_comb begin
        IF    = (state == FETCH) && i_data_valid;
        ID    = (state == DECODE);
        EX    = (state == EXEC);
        MEM   = (state == MEMACC) && mem_done;
        WB    = (state == WRBACK) && wb_q;
        i_req = (state == FETCH);
        d_req = (state == MEMACC) && mem_q;
        busy  = (state != IDLE) && (state != ERR);
        error = (state == ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mem_q        <= 1'b0;
            wb_q         <= 1'b0;
            halt_q       <= 1'b0;
            wait_cnt     <= '0;
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            // Set has priority over the IDLE/enable=0 clear.
            if (halt_req)
                halt_q <= 1'b1;
            else if ((state == IDLE) && !enable)
                halt_q <= 1'b0;

            if (waiting && (TIMEOUT != 0))
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;

            if (waiting && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (boundary && (retired != '1))
                retired <= retired + CNT_W'(1);

            if (timeout_hit) begin
                state <= ERR;
            end else begin
                case (state)
                    IDLE:   if (enable && !halt_q) state <= FETCH;
                    FETCH:  if (i_data_valid) state <= DECODE;
                    DECODE: begin
                        mem_q <= mem_op;
                        wb_q  <= wb_en;
                        state <= EXEC;
                    end
                    EXEC: begin
                        if (mem_q || !SKIP)
                            state <= MEMACC;
                        else if (wb_q)
                            state <= WRBACK;
                        else
                            state <= after_bnd;
                    end
                    MEMACC: begin
                        if (mem_done)
                            state <= (wb_q || !SKIP) ? WRBACK : after_bnd;
                    end
                    WRBACK: state <= after_bnd;
                    default: state <= ERR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dlx_sequencer.sv
module tb_dlx_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0, halt_req = 1'b0, i_v = 1'b0, d_v = 1'b0;
    logic mem_op = 1'b0, wb_en = 1'b0;

    logic a_if, a_id, a_ex, a_mem, a_wb, a_ireq, a_dreq, a_busy, a_err;
    logic b_if, b_id, b_ex, b_mem, b_wb, b_ireq, b_dreq, b_busy, b_err;
    logic c_if, c_id, c_ex, c_mem, c_wb, c_ireq, c_dreq, c_busy, c_err;
    logic [31:0] a_ret, a_stall, b_ret, b_stall;
    logic [2:0]  c_ret, c_stall;

    int compared = 0;
    int mismatched = 0;
    logic [8:0] sb[$];
    logic [8:0] e, got;

    always #5 clk = ~clk;

    dlx_sequencer #(.TIMEOUT(16), .CNT_W(32), .SKIP_MEM(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .halt_req(halt_req),
        .i_data_valid(i_v), .d_data_valid(d_v), .mem_op(mem_op), .wb_en(wb_en),
        .IF(a_if), .ID(a_id), .EX(a_ex), .MEM(a_mem), .WB(a_wb),
        .i_req(a_ireq), .d_req(a_dreq), .busy(a_busy), .error(a_err),
        .retired(a_ret), .stall_cycles(a_stall));

    dlx_sequencer #(.TIMEOUT(16), .CNT_W(32), .SKIP_MEM(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .halt_req(halt_req),
        .i_data_valid(i_v), .d_data_valid(d_v), .mem_op(mem_op), .wb_en(wb_en),
        .IF(b_if), .ID(b_id), .EX(b_ex), .MEM(b_mem), .WB(b_wb),
        .i_req(b_ireq), .d_req(b_dreq), .busy(b_busy), .error(b_err),
        .retired(b_ret), .stall_cycles(b_stall));

    dlx_sequencer #(.TIMEOUT(0), .CNT_W(3), .SKIP_MEM(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .halt_req(halt_req),
        .i_data_valid(i_v), .d_data_valid(d_v), .mem_op(mem_op), .wb_en(wb_en),
        .IF(c_if), .ID(c_id), .EX(c_ex), .MEM(c_mem), .WB(c_wb),
        .i_req(c_ireq), .d_req(c_dreq), .busy(c_busy), .error(c_err),
        .retired(c_ret), .stall_cycles(c_stall));

    // Bit order: IF ID EX MEM WB i_req d_req busy error
    function automatic logic [8:0] mk(input string p);
        case (p)
            "F":  return 9'b100001010;
            "Fw": return 9'b000001010;
            "D":  return 9'b010000010;
            "E":  return 9'b001000010;
            "M":  return 9'b000100110;
            "Mw": return 9'b000000110;
            "M0": return 9'b000100010;
            "W":  return 9'b000010010;
            "W0": return 9'b000000010;
            "X":  return 9'b000000001;
            default: return 9'b000000000;
        endcase
    endfunction

    function automatic logic [8:0] obs_a();
        return {a_if, a_id, a_ex, a_mem, a_wb, a_ireq, a_dreq, a_busy, a_err};
    endfunction
    function automatic logic [8:0] obs_b();
        return {b_if, b_id, b_ex, b_mem, b_wb, b_ireq, b_dreq, b_busy, b_err};
    endfunction
    function automatic logic [8:0] obs_c();
        return {c_if, c_id, c_ex, c_mem, c_wb, c_ireq, c_dreq, c_busy, c_err};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0; halt_req = 1'b0; i_v = 1'b0; d_v = 1'b0;
        mem_op = 1'b0; wb_en = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable = 1'b1; i_v = 1'b1; d_v = 1'b1; wb_en = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (obs_a() !== 9'd0 || obs_b() !== 9'd0 || obs_c() !== 9'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %b/%b/%b want 0", obs_a(), obs_b(), obs_c());
        end
        compared++;
        if (a_ret !== 32'd0 || a_stall !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_counters: got ret=%0d stall=%0d want 0", a_ret, a_stall);
        end
    endtask

    task automatic test_basic();
        string seq[$];
        do_reset();
        seq = '{"I", "F", "D", "E", "W"};
        for (int k = 0; k < 8; k++) seq = {seq, "F", "D", "E", "W"};
        for (int c = 0; c < seq.size(); c++) begin
            enable = 1'b1; i_v = 1'b1; d_v = 1'b1; mem_op = 1'b0; wb_en = 1'b1;
            sb.push_back(mk(seq[c]));
            @(negedge clk);
            e = sb.pop_front(); got = obs_a();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL basic_phase cyc %0d: got %b want %b", c, got, e);
            end
            if (c == 5) begin
                compared++;
                if (a_ret !== 32'd1) begin
                    mismatched++;
                    $display("FAIL basic_retired_first: got %0d want 1", a_ret);
                end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        compared++;
        if (a_ret !== 32'd9) begin
            mismatched++;
            $display("FAIL basic_retired_total: got %0d want 9", a_ret);
        end
        compared++;
        if (c_ret !== 3'd7) begin
            mismatched++;
            $display("FAIL retired_saturate: got %0d want 7", c_ret);
        end
    endtask

    task automatic test_load_wait();
        string seq[$];
        do_reset();
        seq = '{"I", "F", "D", "E", "Mw", "Mw", "Mw", "M", "W", "I", "I"};
        for (int c = 0; c < seq.size(); c++) begin
            enable = (c < 5); i_v = 1'b1; d_v = (c >= 7); mem_op = 1'b1; wb_en = 1'b1;
            sb.push_back(mk(seq[c]));
            @(negedge clk);
            e = sb.pop_front(); got = obs_a();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL load_phase cyc %0d: got %b want %b", c, got, e);
            end
            if (c == 9) begin
                compared++;
                if (a_stall !== 32'd3 || a_ret !== 32'd1) begin
                    mismatched++;
                    $display("FAIL load_counters: got stall=%0d ret=%0d want 3/1", a_stall, a_ret);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        string seq[$];
        do_reset();
        seq = '{"I"};
        for (int k = 0; k < 16; k++) seq = {seq, "Fw"};
        seq = {seq, "X", "X", "X", "X"};
        for (int c = 0; c < seq.size(); c++) begin
            enable = 1'b1; i_v = (c >= 19); d_v = 1'b0; mem_op = 1'b0; wb_en = 1'b1;
            sb.push_back(mk(seq[c]));
            @(negedge clk);
            e = sb.pop_front(); got = obs_a();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL timeout_phase cyc %0d: got %b want %b", c, got, e);
            end
            if (c == 17) begin
                compared++;
                if (a_stall !== 32'd16 || a_ret !== 32'd0) begin
                    mismatched++;
                    $display("FAIL timeout_counters: got stall=%0d ret=%0d want 16/0", a_stall, a_ret);
                end
            end
            if (c == 18) begin
                compared++;
                if (obs_c() !== mk("Fw")) begin
                    mismatched++;
                    $display("FAIL no_timeout_when_zero: got %b want %b", obs_c(), mk("Fw"));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt();
        string seq[$];
        do_reset();
        seq = '{"I", "F", "D", "E", "W", "I", "I", "I", "I", "F"};
        for (int c = 0; c < seq.size(); c++) begin
            enable = (c != 7); halt_req = (c == 3); i_v = 1'b1; d_v = 1'b1;
            mem_op = 1'b0; wb_en = 1'b1;
            sb.push_back(mk(seq[c]));
            @(negedge clk);
            e = sb.pop_front(); got = obs_a();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL halt_phase cyc %0d: got %b want %b", c, got, e);
            end
            @(posedge clk); #1;
        end
        halt_req = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        string seq[$];
        do_reset();
        seq = '{"I", "F", "D", "E", "Mw", "Mw", "I", "I", "I"};
        for (int c = 0; c < seq.size(); c++) begin
            enable = (c < 7); i_v = 1'b1; d_v = 1'b0; mem_op = 1'b1; wb_en = 1'b1;
            if (c == 6) begin #2 reset_n = 1'b0; end
            if (c == 7) reset_n = 1'b1;
            sb.push_back(mk(seq[c]));
            @(negedge clk);
            e = sb.pop_front(); got = obs_a();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL rstmem_phase cyc %0d: got %b want %b", c, got, e);
            end
            if (c == 5) begin
                compared++;
                if (a_stall !== 32'd1) begin
                    mismatched++;
                    $display("FAIL rstmem_stall_before: got %0d want 1", a_stall);
                end
            end
            if (c == 6) begin
                compared++;
                if (a_stall !== 32'd0 || a_ret !== 32'd0) begin
                    mismatched++;
                    $display("FAIL rstmem_counters: got stall=%0d ret=%0d want 0/0", a_stall, a_ret);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_skip();
        string seq[$];
        do_reset();
        seq = '{"I", "F", "D", "E", "M0", "W0", "I"};
        for (int c = 0; c < seq.size(); c++) begin
            enable = (c < 3); i_v = 1'b1; d_v = 1'b0; mem_op = 1'b0; wb_en = 1'b0;
            sb.push_back(mk(seq[c]));
            @(negedge clk);
            e = sb.pop_front(); got = obs_b();
            compared++;
            if (got !== e) begin
                mismatched++;
                $display("FAIL noskip_phase cyc %0d: got %b want %b", c, got, e);
            end
            if (c == 6) begin
                compared++;
                if (b_ret !== 32'd1 || b_stall !== 32'd0) begin
                    mismatched++;
                    $display("FAIL noskip_counters: got ret=%0d stall=%0d want 1/0", b_ret, b_stall);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_load_wait();
        test_timeout();
        test_halt();
        test_reset_mid_mem();
        test_no_skip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
